// File: rtl/pwm_pkg.sv
// Shared constants for the PWM generator: register map and parameter sanity check.
package pwm_pkg;

  localparam int ADDR_PERIOD   = 0;
  localparam int ADDR_PRESCALE = 1;
  localparam int ADDR_INVERT   = 2;
  localparam int ADDR_DUTY0    = 3;

  // True when every channel's duty register has an address in the map.
  function automatic bit addr_fits(input int addr_bits, input int channels);
    return (ADDR_DUTY0 + channels) <= (1 << addr_bits);
  endfunction

endpackage

// File: rtl/pwm_if.sv
// Write-strobe register port from the CPU-side bus into the PWM generator.
interface pwm_if #(
  parameter int ADDR_BITS = 4,
  parameter int WIDTH     = 16
);
  logic                 wr;
  logic [ADDR_BITS-1:0] addr;
  logic [WIDTH-1:0]     wdata;

  modport master (output wr, addr, wdata);
  modport slave  (input  wr, addr, wdata);
endinterface

// File: rtl/pwm_prescaler.sv
// Clock divider producing a one-cycle tick every prescale+1 clocks while enabled.
module pwm_prescaler #(
  parameter int PRESCALER_BITS = 8
) (
  input  logic                      clk,
  input  logic                      nreset,
  input  logic                      enable,
  input  logic [PRESCALER_BITS-1:0] prescale,
  output logic                      tick
);

  logic [PRESCALER_BITS-1:0] pre_cnt_reg;
  logic [PRESCALER_BITS-1:0] pre_cnt_next;

  always_comb begin
    tick         = enable && (pre_cnt_reg == prescale);
    pre_cnt_next = pre_cnt_reg + PRESCALER_BITS'(1);
    if (!enable || tick) begin
      pre_cnt_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      pre_cnt_reg <= '0;
    end else begin
      pre_cnt_reg <= pre_cnt_next;
    end
  end

endmodule

// File: rtl/pwm_gen.sv
// Multi-channel PWM generator: shared prescaled counter, per-channel duty and
// polarity, shadow registers committed glitch-free at the period wrap.
module pwm_gen
  import pwm_pkg::*;
#(
  parameter int CHANNELS       = 2,
  parameter int WIDTH          = 16,
  parameter int PRESCALER_BITS = 8,
  parameter int ADDR_BITS      = 4
) (
  input  logic                clk,
  input  logic                nreset,
  input  logic                enable,
  pwm_if.slave                bus,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                period_end
);

  localparam bit CFG_OK = addr_fits(ADDR_BITS, CHANNELS);

  generate
    if (!CFG_OK) begin : g_cfg_error
      $error("pwm_gen: 3+CHANNELS exceeds the ADDR_BITS address space");
    end
  endgenerate

  logic [WIDTH-1:0]          shadow_period_reg, shadow_period_next, active_period_reg;
  logic [PRESCALER_BITS-1:0] shadow_prescale_reg, shadow_prescale_next, active_prescale_reg;
  logic [CHANNELS-1:0]       shadow_invert_reg, shadow_invert_next, active_invert_reg;
  logic [WIDTH-1:0]          cnt_reg, cnt_next;
  logic [CHANNELS-1:0]       pwm_out_reg, pwm_next;
  logic                      period_end_reg;
  logic                      tick, wrap, load_active;

  pwm_prescaler #(
    .PRESCALER_BITS(PRESCALER_BITS)
  ) u_prescaler (
    .clk      (clk),
    .nreset   (nreset),
    .enable   (enable),
    .prescale (active_prescale_reg),
    .tick     (tick)
  );

  // The *_next shadow values already contain this cycle's write, so loading
  // active copies from them gives the same-cycle bypass for free.
  always_comb begin
    shadow_period_next   = shadow_period_reg;
    shadow_prescale_next = shadow_prescale_reg;
    shadow_invert_next   = shadow_invert_reg;
    if (bus.wr) begin
      if (bus.addr == ADDR_BITS'(ADDR_PERIOD)) begin
        shadow_period_next = bus.wdata;
      end
      if (bus.addr == ADDR_BITS'(ADDR_PRESCALE)) begin
        shadow_prescale_next = bus.wdata[PRESCALER_BITS-1:0];
      end
      if (bus.addr == ADDR_BITS'(ADDR_INVERT)) begin
        shadow_invert_next = bus.wdata[CHANNELS-1:0];
      end
    end
  end

  always_comb begin
    wrap        = (cnt_reg == active_period_reg);
    load_active = !enable || (tick && wrap);
    cnt_next    = cnt_reg;
    if (!enable) begin
      cnt_next = '0;
    end else if (tick) begin
      cnt_next = wrap ? '0 : cnt_reg + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      shadow_period_reg   <= '0;
      shadow_prescale_reg <= '0;
      shadow_invert_reg   <= '0;
      active_period_reg   <= '0;
      active_prescale_reg <= '0;
      active_invert_reg   <= '0;
      cnt_reg             <= '0;
      pwm_out_reg         <= '0;
      period_end_reg      <= 1'b0;
    end else begin
      shadow_period_reg   <= shadow_period_next;
      shadow_prescale_reg <= shadow_prescale_next;
      shadow_invert_reg   <= shadow_invert_next;
      if (load_active) begin
        active_period_reg   <= shadow_period_next;
        active_prescale_reg <= shadow_prescale_next;
        active_invert_reg   <= shadow_invert_next;
      end
      cnt_reg        <= cnt_next;
      pwm_out_reg    <= pwm_next;
      period_end_reg <= tick && wrap;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      logic [WIDTH-1:0] shadow_duty_reg, shadow_duty_next, active_duty_reg;

      always_comb begin
        shadow_duty_next = shadow_duty_reg;
        if (bus.wr && (bus.addr == ADDR_BITS'(ADDR_DUTY0 + gi))) begin
          shadow_duty_next = bus.wdata;
        end
      end

      always_ff @(posedge clk) begin
        if (!nreset) begin
          shadow_duty_reg <= '0;
          active_duty_reg <= '0;
        end else begin
          shadow_duty_reg <= shadow_duty_next;
          if (load_active) begin
            active_duty_reg <= shadow_duty_next;
          end
        end
      end

      assign pwm_next[gi] = enable ? ((cnt_reg < active_duty_reg) ^ active_invert_reg[gi])
                                   : active_invert_reg[gi];
    end
  endgenerate

  assign pwm_out    = pwm_out_reg;
  assign period_end = period_end_reg;

endmodule
